ltch_readout_ctrl: RTL

Sequencer for the 33-bit enable-gated capture latch bank in the TDC readout path. On each accepted trigger it waits for TDC data to settle, then pulses the latch enable for one cycle. It copies the latched word, tagged with an event number, into an output register. It then delivers that register downstream over a valid/ready handshake, followed by a holdoff window. Triggers arriving while busy are counted as dropped.

---
 rtl/ltch_readout_pkg.sv | 19 +
 rtl/ltch_sat_counter.sv | 21 ++
 rtl/ltch_readout_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/ltch_readout_pkg.sv
// Shared constants and state encoding for the TDC capture-latch readout sequencer.
package ltch_readout_pkg;

  localparam int DATA_W          = 33;
  localparam int DEF_SETTLE_CYC  = 4;
  localparam int DEF_HOLDOFF_CYC = 8;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_EVT_W       = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SETTLE  = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_LOAD    = 3'd3;
  localparam state_t ST_PRESENT = 3'd4;
  localparam state_t ST_HOLDOFF = 3'd5;

endpackage

// File: rtl/ltch_sat_counter.sv
// Width-parameterised up-counter with synchronous clear that sticks at all-ones.
module ltch_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/ltch_readout_ctrl.sv
// Trigger-to-readout sequencer: settle, pulse the latch enable, load the word,
// present it downstream, then hold off before accepting the next trigger.
module ltch_readout_ctrl
  import ltch_readout_pkg::*;
#(
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int EVT_W       = DEF_EVT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              trig,
  output logic              latch_en,
  input  logic [DATA_W-1:0] latch_q,
  output logic [DATA_W-1:0] out_data,
  output logic [EVT_W-1:0]  out_evt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [EVT_W-1:0]  drop_cnt,
  output logic              timeout_flag,
  output state_t            state_dbg
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0]      HOLD_LAST   = 8'(HOLDOFF_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYC - 1);

  // Zero-length settle/holdoff windows skip their state entirely.
  localparam state_t ST_AFTER_TRIG    = (SETTLE_CYC == 0)  ? ST_CAPTURE : ST_SETTLE;
  localparam state_t ST_AFTER_PRESENT = (HOLDOFF_CYC == 0) ? ST_IDLE    : ST_HOLDOFF;

  state_t            state;
  state_t            state_nxt;
  logic              trig_d;
  logic              trig_edge;
  logic              timed_out;
  logic [7:0]        settle_cnt;
  logic [7:0]        hold_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [EVT_W-1:0]  evt_cnt;

  assign trig_edge = trig & ~trig_d;
  assign timed_out = (state == ST_PRESENT) && !out_ready && (to_cnt == TO_LAST);

  // Handshake: out_valid is high for the whole PRESENT state with out_data/out_evt
  // frozen; a word transfers on a rising edge where out_valid & out_ready, and
  // out_valid never drops before that edge except on timeout or reset.
  assign out_valid = (state == ST_PRESENT);
  assign latch_en  = (state == ST_CAPTURE);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (trig_edge && arm) state_nxt = ST_AFTER_TRIG;
      ST_SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = ST_PRESENT;
      ST_PRESENT: if (out_ready || (to_cnt == TO_LAST)) state_nxt = ST_AFTER_PRESENT;
      ST_HOLDOFF: if (hold_cnt == HOLD_LAST) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      trig_d       <= 1'b0;
      settle_cnt   <= '0;
      hold_cnt     <= '0;
      to_cnt       <= '0;
      evt_cnt      <= '0;
      out_data     <= '0;
      out_evt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state  <= state_nxt;
      trig_d <= trig;
      // Each window counter idles at zero so it starts fresh on state entry.
      settle_cnt <= (state == ST_SETTLE)  ? settle_cnt + 8'd1     : '0;
      hold_cnt   <= (state == ST_HOLDOFF) ? hold_cnt + 8'd1       : '0;
      to_cnt     <= (state == ST_PRESENT) ? to_cnt + TO_W'(1)     : '0;
      if (state == ST_LOAD) begin
        out_data <= latch_q;
        out_evt  <= evt_cnt;
        evt_cnt  <= evt_cnt + EVT_W'(1);
      end
      if (timed_out) timeout_flag <= 1'b1;
    end
  end

  ltch_sat_counter #(.W(EVT_W)) u_drop_cnt (
    .clk (clk),
    .clr (~rst_n),
    .inc (trig_edge && arm && (state != ST_IDLE)),
    .cnt (drop_cnt)
  );

endmodule
